// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers shared by Gray counters and async-FIFO pointers.
// Functions work on a max-width vector; callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_vec_t;

    function automatic gray_vec_t bin2gray(input gray_vec_t x);
        return x ^ (x >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result exact.
    function automatic gray_vec_t gray2bin(input gray_vec_t g);
        gray_vec_t b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter_step.sv
// Combinational next-count unit for the Gray up/down counter.
// Produces the next binary count and the wrap-around flag.
module gray_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_up,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_b_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    always_comb begin
        o_b_next = i_b;
        o_wrap   = 1'b0;
        if (i_en) begin
            if (i_up) begin
                o_b_next = i_b + W_ONE;
                o_wrap   = &i_b;
            end else begin
                o_b_next = i_b - W_ONE;
                o_wrap   = ~|i_b;
            end
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray counter with load and wrap pulse.
// Binary count is the source of truth; Gray is re-derived from it each step.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_g;
    logic             r_wrap;

    logic [WIDTH-1:0] w_b_next;
    logic             w_wrap;
    logic [WIDTH-1:0] w_g_step;
    logic [WIDTH-1:0] w_g_load;

    gray_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_b      (r_b),
        .i_up     (up),
        .i_en     (en),
        .o_b_next (w_b_next),
        .o_wrap   (w_wrap)
    );

    assign w_g_step = WIDTH'(bin2gray(gray_vec_t'(w_b_next)));
    assign w_g_load = WIDTH'(bin2gray(gray_vec_t'(load_val)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b    <= '0;
            r_g    <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_b    <= load_val;
            r_g    <= w_g_load;
            r_wrap <= 1'b0;
        end else begin
            r_b    <= w_b_next;
            r_g    <= w_g_step;
            r_wrap <= w_wrap;
        end
    end

    assign gray = r_g;
    assign bin  = r_b;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter at WIDTH=4 and WIDTH=8.
// Both instances share stimulus; an integer count model predicts each cycle.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;

    logic [3:0] gray4, bin4;
    logic       wrap4;
    logic [7:0] gray8, bin8;
    logic       wrap8;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]),
        .gray(gray4), .bin(bin4), .wrap(wrap4)
    );

    gray_updown_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val),
        .gray(gray8), .bin(bin8), .wrap(wrap8)
    );

    typedef struct {
        int  g4, b4, w4, pg4;
        int  g8, b8, w8, pg8;
        bit  s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int   m4 = 0, m8 = 0;
    bit   cap = 0;
    int   glog[$];
    int   wcnt8 = 0;

    int   tbl[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int g2b(input int g, input int w);
        int b = 0;
        for (int i = 0; i < w; i++) begin
            if ((^(g >> i)) == 1'b1) b = b | (1 << i);
        end
        return b;
    endfunction

    function automatic int tog(input int g);
        return g ^ (g >> 1);
    endfunction

    // Reference: integer count with modulo arithmetic, reset > load > en.
    task automatic drive(input bit e, input bit u, input bit l, input int lv);
        exp_t x;
        en = e;
        up = u;
        load = l;
        load_val = 8'(lv);
        x.pg4 = tog(m4);
        x.pg8 = tog(m8);
        x.w4 = 0;
        x.w8 = 0;
        x.s = 0;
        if (rst) begin
            m4 = 0;
            m8 = 0;
        end else if (l) begin
            m4 = lv % 16;
            m8 = lv % 256;
        end else if (e) begin
            x.s = 1;
            if (u) begin
                x.w4 = (m4 == 15);
                x.w8 = (m8 == 255);
                m4 = (m4 + 1) % 16;
                m8 = (m8 + 1) % 256;
            end else begin
                x.w4 = (m4 == 0);
                x.w8 = (m8 == 0);
                m4 = (m4 + 15) % 16;
                m8 = (m8 + 255) % 256;
            end
        end
        x.b4 = m4;
        x.g4 = tog(m4);
        x.b8 = m8;
        x.g8 = tog(m8);
        q.push_back(x);
    endtask

    task automatic step(input bit e, input bit u, input bit l, input int lv);
        drive(e, u, l, lv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        load = 1'b0;
        #1;
        chk("rst_gray4", int'(gray4), 0);
        chk("rst_bin8", int'(bin8), 0);
        chk("rst_wrap4", int'(wrap4), 0);
        m4 = 0;
        m8 = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one sample per cycle, just after the rising edge.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("gray4", int'(gray4), x.g4);
            chk("bin4", int'(bin4), x.b4);
            chk("wrap4", int'(wrap4), x.w4);
            chk("gray8", int'(gray8), x.g8);
            chk("bin8", int'(bin8), x.b8);
            chk("wrap8", int'(wrap8), x.w8);
            chk("g2b4", g2b(int'(gray4), 4), int'(bin4));
            chk("g2b8", g2b(int'(gray8), 8), int'(bin8));
            if (x.s) begin
                chk("onebit4", $countones(int'(gray4) ^ x.pg4), 1);
                chk("onebit8", $countones(int'(gray8) ^ x.pg8), 1);
            end
            if (cap) glog.push_back(int'(gray4));
            if (wrap8) wcnt8++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Up-count through a full WIDTH=4 cycle and compare against the table.
        cap = 1;
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
        cap = 0;
        chk("seq_len", glog.size(), 16);
        for (int i = 0; i < 16 && i < glog.size(); i++) chk("seq_gray", glog[i], tbl[i]);

        // Down from zero wraps to all ones, then continues down.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Load wins over enable, then hold.
        step(1, 1, 1, 10);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

        // Direction reversal at 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // Async reset 2 ns after the edge that reaches 7.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bin4", int'(bin4), 0);
        chk("arst_gray4", int'(gray4), 0);
        chk("arst_bin8", int'(bin8), 0);
        @(negedge clk);
        step(1, 1, 0, 0);
        rst = 1'b0;
        step(1, 1, 0, 0);

        // WIDTH=8 free run: exactly one wrap in 256 steps.
        do_reset();
        wcnt8 = 0;
        for (int i = 0; i < 256; i++) step(1, 1, 0, 0);
        chk("wraps8", wcnt8, 1);

        // Randomised mix of load, enable and direction.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)));
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("q_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
